// File: rtl/onchip_mem_stream_reader_pkg.sv
// Shared types for the on-chip memory stream reader.
// Holds the FSM state encoding, default widths and the output buffer entry layout.
package onchip_mem_stream_reader_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  // Stream framing flags travel with each buffered word.
  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_W_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/stream_fwft_fifo.sv
// First-word-fall-through FIFO with a synchronous reset and an occupancy count.
// The head entry is visible on pop_data whenever empty is low.
module stream_fwft_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master that plays back a contiguous run of on-chip memory words
// onto an Avalon-ST source with sop/eop framing and backpressure.
module onchip_mem_stream_reader
  import onchip_mem_stream_reader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  output logic              m_clken,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   issued_q;
  logic              in_flight_q;
  logic              in_flight_sop_q;
  logic              in_flight_eop_q;
  logic              done_q, done_d;
  logic              issue_en;
  logic              cmd_accept;
  logic              credit_ok;
  logic              last_issue;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  fifo_entry_t       push_entry;
  fifo_entry_t       pop_entry;

  assign m_write      = 1'b0;
  assign m_byteenable = 4'hF;
  assign m_clken      = 1'b1;
  assign m_address    = addr_q;
  assign m_chipselect = issue_en;
  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  // A read may only be issued if its word is guaranteed a FIFO slot on return.
  assign credit_ok  = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(in_flight_q)) < (CNT_W+1)'(FIFO_DEPTH);
  assign last_issue = (issued_q == (len_q - (ADDR_W+1)'(1)));

  assign push_entry.sop  = in_flight_sop_q;
  assign push_entry.eop  = in_flight_eop_q;
  assign push_entry.data = m_readdata;

  assign st_valid = !fifo_empty;
  assign st_data  = pop_entry.data;
  assign st_sop   = pop_entry.sop;
  assign st_eop   = pop_entry.eop;
  assign pop      = st_valid && st_ready;

  stream_fwft_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight_q),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (pop_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Completion is flagged as the final word leaves, so done lands one cycle after the eop pop.
  always_comb begin
    state_d    = state_q;
    issue_en   = 1'b0;
    cmd_accept = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_accept = 1'b1;
          if (cmd_len == '0) done_d  = 1'b1;
          else               state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue_en = 1'b1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!in_flight_q && (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      in_flight_q     <= 1'b0;
      in_flight_sop_q <= 1'b0;
      in_flight_eop_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      in_flight_q <= issue_en;
      if (cmd_accept) begin
        addr_q   <= cmd_base;
        len_q    <= cmd_len;
        issued_q <= '0;
      end else if (issue_en) begin
        addr_q          <= addr_q + ADDR_W'(1);
        issued_q        <= issued_q + (ADDR_W+1)'(1);
        in_flight_sop_q <= (issued_q == '0);
        in_flight_eop_q <= last_issue;
      end
    end
  end

endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Directed bench for onchip_mem_stream_reader against a latency-1 memory model
// preloaded with word i = 0xA5000000 + i.
module tb_onchip_mem_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [14:0] cmd_base;
  logic [15:0] cmd_len;
  logic [14:0] m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic        m_clken;
  logic [31:0] m_readdata = 32'h0;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [14:0] base;
    logic [15:0] len;
    int          mode;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_chipselect) m_readdata <= 32'hA500_0000 + {17'd0, m_address};
  end

  onchip_mem_stream_reader dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base     (cmd_base),
    .cmd_len      (cmd_len),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_sop       (st_sop),
    .st_eop       (st_eop),
    .busy         (busy),
    .done         (done)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  // mode 0: st_ready always high; mode 2: st_ready low 10 cycles, then random.
  // abort_after > 0 raises reset right after that many beats have been popped.
  task automatic applyStimulus(input logic [14:0] base, input logic [15:0] len, input int mode,
                               input int abort_after, output int beats,
                               output logic [31:0] first_d, output logic [31:0] last_d);
    int          issued;
    int          done_i;
    int          eop_i;
    int          first_valid_i;
    bit          busy_seen;
    bit          prev_stall;
    logic [33:0] prev_beat;
    logic [14:0] exp_addr;
    logic [31:0] exp_data;
    checkOutput("cmd_ready_before_cmd", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_base  = base;
    cmd_len   = len;
    st_ready  = (mode == 0);
    beats = 0; issued = 0; done_i = -1; eop_i = -1; first_valid_i = -1;
    busy_seen = 1'b0; prev_stall = 1'b0; prev_beat = '0; first_d = '0; last_d = '0;
    for (int i = 1; i <= 3000 && done_i < 0; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      st_ready  = (mode == 0) ? 1'b1 : ((i > 10) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (busy) busy_seen = 1'b1;
      if (m_chipselect) begin
        exp_addr = base + 15'(issued);
        checkOutput("m_address", 64'(m_address), 64'(exp_addr));
        issued++;
      end
      if (prev_stall)
        checkOutput("stall_stable", {30'd0, st_valid, st_sop, st_eop, st_data}, {30'd0, 1'b1, prev_beat});
      if (st_valid && first_valid_i < 0) first_valid_i = i;
      if (st_valid && st_ready) begin
        exp_addr = base + 15'(beats);
        exp_data = 32'hA500_0000 + {17'd0, exp_addr};
        checkOutput("st_data", 64'(st_data), 64'(exp_data));
        checkOutput("st_sop", 64'(st_sop), 64'(beats == 0));
        checkOutput("st_eop", 64'(st_eop), 64'(beats == int'(len) - 1));
        if (beats == 0) first_d = st_data;
        last_d = st_data;
        if (st_eop) eop_i = i;
        beats++;
      end
      prev_stall = st_valid && !st_ready;
      prev_beat  = {st_sop, st_eop, st_data};
      if (done) done_i = i;
      if (mode == 2 && i == 10) begin
        checkOutput("credit_stop_issued", 64'(issued), 64'(4));
        checkOutput("credit_stop_beats", 64'(beats), 64'(0));
      end
      if (abort_after > 0 && beats == abort_after) begin
        reset = 1'b1;
        return;
      end
    end
    checkOutput("done_seen", 64'(done_i > 0), 64'(1));
    checkOutput("beat_count", 64'(beats), 64'(len));
    checkOutput("issue_count", 64'(issued), 64'(len));
    if (len == 16'd0) begin
      checkOutput("len0_done_latency", 64'(done_i), 64'(1));
      checkOutput("len0_busy", 64'(busy_seen), 64'(0));
    end else begin
      checkOutput("done_after_eop", 64'(done_i), 64'(eop_i + 1));
      checkOutput("busy_seen", 64'(busy_seen), 64'(1));
      if (mode == 0) checkOutput("first_valid_latency", 64'(first_valid_i), 64'(3));
    end
  endtask

  initial begin
    int          beats;
    logic [31:0] first_d;
    logic [31:0] last_d;
    bit          done_during_abort;

    vecs[0] = '{base: 15'h0010, len: 16'd8,  mode: 0, exp_first: 32'hA500_0010, exp_last: 32'hA500_0017};
    vecs[1] = '{base: 15'h7FFE, len: 16'd4,  mode: 0, exp_first: 32'hA500_7FFE, exp_last: 32'hA500_0001};
    vecs[2] = '{base: 15'h0123, len: 16'd0,  mode: 0, exp_first: 32'h0,         exp_last: 32'h0};
    vecs[3] = '{base: 15'h0200, len: 16'd16, mode: 2, exp_first: 32'hA500_0200, exp_last: 32'hA500_020F};

    reset = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; st_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("reset_chipselect", 64'(m_chipselect), 64'(0));
    checkOutput("reset_address", 64'(m_address), 64'(0));
    checkOutput("reset_st_valid", 64'(st_valid), 64'(0));
    checkOutput("reset_busy_done", {62'd0, busy, done}, 64'(0));
    checkOutput("tie_offs", {57'd0, m_write, m_byteenable, m_clken}, {57'd0, 1'b0, 4'hF, 1'b1});
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      $display("[TB] command base=%h len=%0d mode=%0d", vecs[v].base, vecs[v].len, vecs[v].mode);
      applyStimulus(vecs[v].base, vecs[v].len, vecs[v].mode, 0, beats, first_d, last_d);
      if (vecs[v].len != 16'd0) begin
        checkOutput("first_word", 64'(first_d), 64'(vecs[v].exp_first));
        checkOutput("last_word", 64'(last_d), 64'(vecs[v].exp_last));
      end
      @(negedge clk);
      checkOutput("done_single_pulse", 64'(done), 64'(0));
    end

    // len=1 followed by a second command accepted on the done cycle itself.
    applyStimulus(15'h0005, 16'd1, 0, 0, beats, first_d, last_d);
    checkOutput("len1_word", 64'(first_d), 64'(32'hA500_0005));
    checkOutput("b2b_done_cycle", 64'(done), 64'(1));
    applyStimulus(15'h0040, 16'd2, 0, 0, beats, first_d, last_d);
    checkOutput("b2b_last_word", 64'(last_d), 64'(32'hA500_0041));
    @(negedge clk);
    checkOutput("b2b_done_single", 64'(done), 64'(0));

    // Reset after three beats of a ten-word command aborts it without a done pulse.
    applyStimulus(15'h0300, 16'd10, 0, 3, beats, first_d, last_d);
    checkOutput("abort_beats", 64'(beats), 64'(3));
    @(negedge clk);
    checkOutput("abort_st_valid", 64'(st_valid), 64'(0));
    checkOutput("abort_chipselect", 64'(m_chipselect), 64'(0));
    checkOutput("abort_cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("abort_done", 64'(done), 64'(0));
    reset = 1'b0;
    done_during_abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || st_valid || m_chipselect) done_during_abort = 1'b1;
    end
    checkOutput("abort_quiet", 64'(done_during_abort), 64'(0));
    applyStimulus(15'h0400, 16'd3, 0, 0, beats, first_d, last_d);
    checkOutput("post_abort_first", 64'(first_d), 64'(32'hA500_0400));
    checkOutput("post_abort_last", 64'(last_d), 64'(32'hA500_0402));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
